// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Contents: FSM state enum, row drive patterns, key code type, and a helper
// that picks the lowest-index low column.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN        = 2'd0,
    ST_DEB_PRESS   = 2'd1,
    ST_HOLD        = 2'd2,
    ST_DEB_RELEASE = 2'd3
  } state_t;

  typedef logic [3:0] key_code_t;

  // Active-low row drive, indexed by row number.
  localparam logic [3:0] ROW_PATTERN [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // col[0] has highest priority when several keys in a row are down.
  function automatic logic [1:0] low_col_idx(input logic [3:0] pat);
    if (!pat[0])      return 2'd0;
    else if (!pat[1]) return 2'd1;
    else if (!pat[2]) return 2'd2;
    else              return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Scan tick generator plus equal-pattern (debounce) counter.
// Ports:
//   clk, rst_n : clock, async active-low reset (already release-synchronised)
//   i_clr      : clear the debounce count (priority over i_inc)
//   i_inc      : count this tick as a stable one (acts only with o_tick)
//   o_tick     : one-cycle pulse every SCAN_DIV clocks
//   o_last     : count is at DEBOUNCE_TICKS-1, so the next stable tick completes
module keypad_debounce #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tick,
  output logic o_last
);
  import keypad_pkg::*;

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_div == DIV_W'(SCAN_DIV - 1));
  assign o_tick = w_wrap;
  assign o_last = (r_cnt == CNT_W'(DEBOUNCE_TICKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_div <= '0;
    else if (w_wrap) r_div <= '0;
    else             r_div <= r_div + DIV_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_inc && w_wrap && (r_cnt != CNT_W'(DEBOUNCE_TICKS)))
      r_cnt <= r_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with debounce and a valid/ready event output.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   col[3:0]  (in)       : active-low columns, asynchronous
//   row[3:0]  (out)      : active-low row drive, one bit low
//   key_code  (out)      : row*4 + col of the accepted key
//   key_valid (out)      : event pending, held until key_ready
//   key_ready (in)       : consumer accepts the event
//   key_down  (out)      : debounced key-held level
// Build option: KEYPAD_AUTOREPEAT_EN re-issues the held key every REPEAT_TICKS ticks.
//
// state          | meaning
// ST_SCAN        | rotating rows looking for a low column (frozen while an event is pending)
// ST_DEB_PRESS   | row frozen, waiting for the latched pattern to stay stable
// ST_HOLD        | key accepted and held
// ST_DEB_RELEASE | columns all high, waiting for the release to stay stable
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_TICKS   = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_down
);
  import keypad_pkg::*;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit AUTOREPEAT_EN = 1'b1;
`else
  localparam bit AUTOREPEAT_EN = 1'b0;
`endif
  localparam int RPT_W = $clog2(REPEAT_TICKS + 1);

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  logic [3:0]       r_col_s1, r_col_s2;
  state_t           r_state, w_state_nxt;
  logic [1:0]       r_row_idx;
  logic [3:0]       r_pat;
  key_code_t        r_key_code;
  logic             r_key_valid, r_key_down;
  logic [RPT_W-1:0] r_rpt_cnt;
  logic             w_tick, w_last;
  logic             w_cnt_clr, w_cnt_inc, w_rotate, w_latch, w_accept, w_release;
  logic             w_rpt_tick, w_rpt_fire;

  // Reset asserts immediately, releases two clocks later on a clean edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_col_s1 <= 4'hF;
      r_col_s2 <= 4'hF;
    end else begin
      r_col_s1 <= col;
      r_col_s2 <= r_col_s1;
    end
  end

  keypad_debounce #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (w_rst_n),
    .i_clr  (w_cnt_clr),
    .i_inc  (w_cnt_inc),
    .o_tick (w_tick),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_SCAN;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_rotate    = 1'b0;
    w_latch     = 1'b0;
    w_accept    = 1'b0;
    w_release   = 1'b0;
    w_rpt_tick  = 1'b0;
    case (r_state)
      ST_SCAN: begin
        // A pending event freezes the scan so no second press can start.
        if (w_tick && !r_key_valid) begin
          if (r_col_s2 != 4'hF) begin
            w_latch     = 1'b1;
            w_cnt_clr   = 1'b1;
            w_state_nxt = ST_DEB_PRESS;
          end else begin
            w_rotate = 1'b1;
          end
        end
      end
      ST_DEB_PRESS: begin
        if (w_tick) begin
          if (r_col_s2 == r_pat) begin
            if (w_last) begin
              w_accept    = 1'b1;
              w_cnt_clr   = 1'b1;
              w_state_nxt = ST_HOLD;
            end else begin
              w_cnt_inc = 1'b1;
            end
          end else begin
            w_state_nxt = ST_SCAN;
          end
        end
      end
      ST_HOLD: begin
        if (w_tick) begin
          if (r_col_s2 == 4'hF) begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = ST_DEB_RELEASE;
          end else begin
            w_rpt_tick = 1'b1;
          end
        end
      end
      ST_DEB_RELEASE: begin
        if (w_tick) begin
          if (r_col_s2 == 4'hF) begin
            if (w_last) begin
              w_release   = 1'b1;
              w_cnt_clr   = 1'b1;
              w_state_nxt = ST_SCAN;
            end else begin
              w_cnt_inc = 1'b1;
            end
          end else begin
            w_state_nxt = ST_HOLD;
          end
        end
      end
      default: w_state_nxt = ST_SCAN;
    endcase
  end

  assign w_rpt_fire = AUTOREPEAT_EN && w_rpt_tick && !r_key_valid &&
                      (r_rpt_cnt == RPT_W'(REPEAT_TICKS - 1));

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_row_idx   <= 2'd0;
      r_pat       <= 4'hF;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
      r_rpt_cnt   <= '0;
    end else begin
      if (w_rotate) r_row_idx <= r_row_idx + 2'd1;
      if (w_latch)  r_pat <= r_col_s2;
      if (w_accept) r_key_code <= {r_row_idx, low_col_idx(r_pat)};

      if (w_accept)       r_key_down <= 1'b1;
      else if (w_release) r_key_down <= 1'b0;

      if (w_accept || w_rpt_fire)      r_key_valid <= 1'b1;
      else if (r_key_valid && key_ready) r_key_valid <= 1'b0;

      // Outside HOLD the count sits at zero, so every entry to HOLD starts fresh.
      if (r_state != ST_HOLD)
        r_rpt_cnt <= '0;
      else if (w_rpt_tick)
        r_rpt_cnt <= (r_rpt_cnt == RPT_W'(REPEAT_TICKS - 1)) ? '0 : r_rpt_cnt + RPT_W'(1);
    end
  end

  assign row       = ROW_PATTERN[r_row_idx];
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_down  = r_key_down;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        key_down;
  logic [15:0] mask;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ev_count = 0;
  int ev_cycle = 0;
  logic [3:0] exp_q [$];

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_TICKS(3), .REPEAT_TICKS(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_down  (key_down)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Keypad matrix: a pressed key pulls its column low when its row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (mask[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: each handshake is one event; compare against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && key_valid && key_ready) begin
      ev_count++;
      ev_cycle = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event actual=%0d required=none", key_code);
      end else begin
        check("event_code", int'(key_code), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_row_enter(input logic [3:0] v);
    logic [3:0] p;
    bit ok;
    ok = 1'b0;
    p = row;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (row == v && p != v) begin
        ok = 1'b1;
        break;
      end
      p = row;
    end
    check("row_enter", int'(ok), 1);
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (!key_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(key_valid), 1);
  endtask

  task automatic wait_up(input string name);
    int n;
    n = 0;
    while (key_down && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(key_down), 0);
  endtask

  task automatic wait_events(input int target);
    int n;
    n = 0;
    while (ev_count < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("event_count_reached", ev_count, target);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 key_ready = v;
  endtask

  initial begin
    int n, base, c0;
    logic [3:0] prev;
    bit seen;

    rst_n = 1'b0;
    mask = 16'h0;
    key_ready = 1'b0;
    #1;
    check("rst_row", int'(row), 4'b1110);
    check("rst_valid", int'(key_valid), 0);
    check("rst_code", int'(key_code), 0);
    check("rst_down", int'(key_down), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Idle rotation: period 4 clocks, left rotate of the low bit.
    wait_row_enter(4'b1101);
    prev = row;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (row == prev && n < 20);
      check("rot_period", n, 4);
      check("rot_value", int'(row), int'({prev[2:0], prev[3]}));
      check("idle_valid", int'(key_valid), 0);
      prev = row;
    end

    // Key 6: row 1, col 2. Latency 2 sync + 1 tick to detect + 3 debounce ticks.
    exp_q.push_back(4'd6);
    wait_row_enter(4'b1101);
    mask = 16'h0040;
    wait_valid("k6_valid", n);
    check("k6_latency", n, 16);
    check("k6_code", int'(key_code), 6);
    check("k6_down", int'(key_down), 1);
    check("k6_row_frozen", int'(row), 4'b1101);
    repeat (5) @(negedge clk);
    check("k6_valid_held", int'(key_valid), 1);
    set_ready(1'b1);
    @(negedge clk);
    @(negedge clk);
    check("k6_valid_clear", int'(key_valid), 0);
    mask = 16'h0;
    wait_up("k6_release");

    // Bounce on alternating ticks on key 8: never accepted, scan resumes.
    wait_row_enter(4'b1011);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      mask = (k % 2 == 0) ? 16'h0100 : 16'h0000;
      repeat (4) begin
        @(negedge clk);
        if (key_valid) seen = 1'b1;
      end
    end
    mask = 16'h0;
    check("bounce_no_event", int'(seen), 0);
    wait_row_enter(4'b0111);

    // Two keys in row 3 (13, 14) plus key 2 in row 0: only 13 reported.
    exp_q.push_back(4'd13);
    wait_row_enter(4'b0111);
    mask = 16'h6004;
    wait_valid("multi_valid", n);
    repeat (40) @(negedge clk);
    mask = 16'h0;
    wait_up("multi_release");
    repeat (40) @(negedge clk);

    // Key 0 with consumer stalled, then key 15 pressed while event pending.
    set_ready(1'b0);
    exp_q.push_back(4'd0);
    wait_row_enter(4'b1110);
    mask = 16'h0001;
    wait_valid("k0_valid", n);
    mask = 16'h0;
    wait_up("k0_release");
    mask = 16'h8000;
    repeat (40) @(negedge clk);
    check("stall_code", int'(key_code), 0);
    check("stall_valid", int'(key_valid), 1);
    check("stall_row", int'(row), 4'b1110);
    exp_q.push_back(4'd15);
    base = ev_count;
    set_ready(1'b1);
    wait_events(base + 2);
    mask = 16'h0;
    wait_up("k15_release");
    repeat (40) @(negedge clk);

    // Reset during DEB_PRESS discards the press.
    wait_row_enter(4'b1011);
    mask = 16'h0200;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_row", int'(row), 4'b1110);
    check("mid_rst_valid", int'(key_valid), 0);
    check("mid_rst_down", int'(key_down), 0);
    mask = 16'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (key_valid) seen = 1'b1;
    end
    check("post_rst_no_event", int'(seen), 0);

    // Key 9 held with consumer ready.
    base = ev_count;
`ifdef KEYPAD_AUTOREPEAT_EN
    repeat (3) exp_q.push_back(4'd9);
    mask = 16'h0200;
    wait_events(base + 1);
    c0 = ev_cycle;
    wait_events(base + 2);
    check("repeat_interval_1", ev_cycle - c0, 20);
    c0 = ev_cycle;
    wait_events(base + 3);
    check("repeat_interval_2", ev_cycle - c0, 20);
    mask = 16'h0;
    wait_up("k9_release");
    repeat (40) @(negedge clk);
    check("k9_events", ev_count - base, 3);
`else
    exp_q.push_back(4'd9);
    mask = 16'h0200;
    wait_events(base + 1);
    c0 = ev_cycle;
    repeat (200) @(negedge clk);
    mask = 16'h0;
    wait_up("k9_release");
    repeat (40) @(negedge clk);
    check("k9_events", ev_count - base, 1);
    check("k9_down_cleared", int'(key_down), 0);
`endif

    repeat (20) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
